// File: rtl/image_crop.sv
// image_crop: forwards only pixels inside a programmable row/column window of a typed pixel stream.
// Defining IMAGE_CROP_DECIMATE_EN adds a decimate input that keeps only even rows/columns of the window.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
module image_crop #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic [DIM_WIDTH-1:0]    row_start,
    input  logic [DIM_WIDTH-1:0]    num_rows,
    input  logic [DIM_WIDTH-1:0]    col_start,
    input  logic [DIM_WIDTH-1:0]    num_cols,
`ifdef IMAGE_CROP_DECIMATE_EN
    input  logic                    decimate,
`endif
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATA_WIDTH-1:0]   datai,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [DATA_WIDTH-1:0]   datao,
    output logic [DIM_WIDTH-1:0]    out_rows,
    output logic [DIM_WIDTH-1:0]    out_cols
);
    localparam logic [`DTYPE_WIDTH-1:0] DT_FS = `DTYPE_WIDTH'(1);
    localparam logic [`DTYPE_WIDTH-1:0] DT_FE = `DTYPE_WIDTH'(2);
    localparam logic [`DTYPE_WIDTH-1:0] DT_RS = `DTYPE_WIDTH'(3);
    localparam logic [`DTYPE_WIDTH-1:0] DT_RE = `DTYPE_WIDTH'(4);
    localparam logic [`DTYPE_WIDTH-1:0] DT_PX = `DTYPE_WIDTH'(5);
    localparam logic [0:0] BYPASS = 1'b0;
    localparam logic [0:0] CROP   = 1'b1;

    logic [0:0]           r_state;
    logic [DIM_WIDTH-1:0] r_row_start, r_num_rows, r_col_start, r_num_cols;
    logic [DIM_WIDTH-1:0] r_row_cnt, r_col_cnt, r_rows, r_pix;
    logic                 r_pend;
    logic                 w_dec, w_row_in, w_col_in, w_row_keep, w_col_keep, w_keep, w_emit;
    logic [DIM_WIDTH:0]   w_row_end, w_col_end;
    logic [DIM_WIDTH-1:0] w_row_off;
    logic [DATA_WIDTH-1:0] w_data;

`ifdef IMAGE_CROP_DECIMATE_EN
    logic r_dec;
    assign w_dec = r_state == CROP && r_dec;
`else
    assign w_dec = 1'b0;
`endif

    function automatic logic [DIM_WIDTH-1:0] sat_inc(input logic [DIM_WIDTH-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction

    // one extra bit so start+count never wraps
    assign w_row_end  = {1'b0, r_row_start} + {1'b0, r_num_rows};
    assign w_col_end  = {1'b0, r_col_start} + {1'b0, r_num_cols};
    assign w_row_in   = r_row_cnt >= r_row_start && (r_num_rows == '0 || {1'b0, r_row_cnt} < w_row_end);
    assign w_col_in   = r_col_cnt >= r_col_start && (r_num_cols == '0 || {1'b0, r_col_cnt} < w_col_end);
    assign w_row_keep = w_row_in && !(w_dec && (r_row_cnt[0] ^ r_row_start[0]));
    assign w_col_keep = w_col_in && !(w_dec && (r_col_cnt[0] ^ r_col_start[0]));
    assign w_row_off  = r_row_cnt - r_row_start;
    assign w_keep     = r_state == BYPASS || (dtypei == DT_PX ? w_row_keep && w_col_keep :
                        (dtypei == DT_RS || dtypei == DT_RE) ? w_row_keep : 1'b1);
    assign w_emit     = dvi && w_keep;
    assign w_data     = (r_state == CROP && dtypei == DT_RS) ?
                        DATA_WIDTH'(w_dec ? w_row_off >> 1 : w_row_off) : datai;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state     <= BYPASS;
            r_row_start <= '0;
            r_num_rows  <= '0;
            r_col_start <= '0;
            r_num_cols  <= '0;
`ifdef IMAGE_CROP_DECIMATE_EN
            r_dec       <= 1'b0;
`endif
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            r_rows      <= '0;
            r_pix       <= '0;
            r_pend      <= 1'b0;
            dvo         <= 1'b0;
            dtypeo      <= '0;
            datao       <= '0;
            out_rows    <= '0;
            out_cols    <= '0;
        end else begin
            dvo    <= w_emit;
            dtypeo <= w_emit ? dtypei : '0;
            datao  <= w_emit ? w_data : '0;
            // stats become visible one cycle after FRAME_END leaves the block
            if (dvo && dtypeo == DT_FE) begin
                out_rows <= r_rows;
                out_cols <= r_pix;
            end
            if (dvi && dtypei == DT_FS) begin
                r_state     <= enable ? CROP : BYPASS;
                r_row_start <= row_start;
                r_num_rows  <= num_rows;
                r_col_start <= col_start;
                r_num_cols  <= num_cols;
`ifdef IMAGE_CROP_DECIMATE_EN
                r_dec       <= decimate;
`endif
                r_row_cnt   <= '0;
                r_col_cnt   <= '0;
                r_rows      <= '0;
                r_pix       <= '0;
                r_pend      <= 1'b0;
            end
            if (dvi && dtypei == DT_RS) begin
                r_col_cnt <= '0;
                if (w_keep) r_pix <= '0;
            end
            if (dvi && dtypei == DT_PX) begin
                r_col_cnt <= sat_inc(r_col_cnt);
                if (w_keep) begin
                    r_pix  <= sat_inc(r_pix);
                    r_pend <= 1'b1;
                end
            end
            if (dvi && dtypei == DT_RE) begin
                r_row_cnt <= sat_inc(r_row_cnt);
                r_col_cnt <= '0;
                if (w_keep) begin
                    r_rows <= sat_inc(r_rows);
                    r_pend <= 1'b0;
                end
            end
            // a last row cut short by FRAME_END still counts if it emitted pixels
            if (dvi && dtypei == DT_FE && r_pend) begin
                r_rows <= sat_inc(r_rows);
                r_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_image_crop.sv
// tb_image_crop: scoreboard bench for image_crop; frames are built from a row/column description
// and the expected stream is derived from the window rules on whole-frame coordinates.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
module tb_image_crop;
    localparam logic [3:0] FS = 4'd1, FE = 4'd2, RS = 4'd3, RE = 4'd4, PX = 4'd5;
    localparam logic [3:0] HS = 4'd6, HD = 4'd7, HE = 4'd8;

    logic        clk = 1'b0;
    logic        resetb = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] row_start = '0, num_rows = '0, col_start = '0, num_cols = '0;
    logic        dvi = 1'b0;
    logic [3:0]  dtypei = '0;
    logic [15:0] datai = '0;
    logic        dvo;
    logic [3:0]  dtypeo;
    logic [15:0] datao, out_rows, out_cols;
`ifdef IMAGE_CROP_DECIMATE_EN
    logic        decimate = 1'b0;
    localparam bit HAS_DEC = 1'b1;
`else
    localparam bit HAS_DEC = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    image_crop #(.DATA_WIDTH(16), .DIM_WIDTH(16)) dut (
        .clk(clk), .resetb(resetb), .enable(enable),
        .row_start(row_start), .num_rows(num_rows), .col_start(col_start), .num_cols(num_cols),
`ifdef IMAGE_CROP_DECIMATE_EN
        .decimate(decimate),
`endif
        .dvi(dvi), .dtypei(dtypei), .datai(datai),
        .dvo(dvo), .dtypeo(dtypeo), .datao(datao), .out_rows(out_rows), .out_cols(out_cols)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        logic [19:0] w;
        total++;
        if (dvo) begin
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word got type=%0d data=%0d want=none", dtypeo, datao);
            end else begin
                w = exp_q.pop_front();
                if ({dtypeo, datao} !== w) begin
                    bad++;
                    $display("FAIL stream_word got type=%0d data=%0d want type=%0d data=%0d",
                             dtypeo, datao, w[19:16], w[15:0]);
                end
            end
        end else if (dtypeo !== '0 || datao !== '0) begin
            bad++;
            $display("FAIL idle_zero got type=%0d data=%0d want 0", dtypeo, datao);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dvi = 1'b0; dtypei = '0; datai = '0;
        end
    endtask

    // optional gap carries junk on the bus to prove dvi gates everything
    task automatic drive(input logic [3:0] t, input logic [15:0] d);
        if ($urandom_range(0, 2) == 2) begin
            @(negedge clk);
            dvi = 1'b0; dtypei = 4'($urandom); datai = 16'($urandom);
        end
        @(negedge clk);
        dvi = 1'b1; dtypei = t; datai = d;
    endtask

    function automatic bit in_win(input int i, input int s, input int n, input bit d, input bit e);
        return !e || (i >= s && (n == 0 || i < s + n) && (!d || ((i - s) % 2 == 0)));
    endfunction

    task automatic put(input logic [3:0] t, input logic [15:0] d, input bit k, input logic [15:0] de,
                       input int abort_at, inout int idx, output bit ab);
        ab = 1'b0;
        drive(t, d);
        if (k) exp_q.push_back({t, de});
        if (idx == abort_at) begin
            @(posedge clk);
            #2 resetb = 1'b0;
            #1;
            chk("reset_dvo", 32'(dvo), 0);
            chk("reset_dtypeo", 32'(dtypeo), 0);
            chk("reset_datao", 32'(datao), 0);
            chk("reset_out_rows", 32'(out_rows), 0);
            exp_q.delete();
            idle(3);
            resetb = 1'b1;
            ab = 1'b1;
        end
        idx++;
    endtask

    task automatic send_frame(input int nr, input int nc, input bit en, input int rs, input int nrw,
                              input int cs, input int ncl, input bit dec, input bit skip_rs0,
                              input bit skip_re, input int mid_rs, input int abort_at, input bit seq);
        int idx = 0;
        int kr = 0;
        int kc = 0;
        int rows_x = 0;
        bit ab, rk, has_re;
        bit dd = en && dec && HAS_DEC;
        logic [15:0] d;
        for (int c = 0; c < nc; c++) kc += int'(in_win(c, cs, ncl, dd, en));
        enable = en; row_start = 16'(rs); num_rows = 16'(nrw); col_start = 16'(cs); num_cols = 16'(ncl);
`ifdef IMAGE_CROP_DECIMATE_EN
        decimate = dec;
`endif
        d = 16'($urandom); put(FS, d, 1, d, abort_at, idx, ab); if (ab) return;
        d = 16'($urandom); put(HS, d, 1, d, abort_at, idx, ab); if (ab) return;
        d = 16'($urandom); put(HD, d, 1, d, abort_at, idx, ab); if (ab) return;
        d = 16'($urandom); put(HD, d, 1, d, abort_at, idx, ab); if (ab) return;
        d = 16'($urandom); put(HE, d, 1, d, abort_at, idx, ab); if (ab) return;
        for (int r = 0; r < nr; r++) begin
            rk = in_win(r, rs, nrw, dd, en);
            has_re = !(r == nr - 1 && skip_re);
            if (!(r == 0 && skip_rs0)) begin
                d = seq ? 16'(r) : 16'($urandom);
                put(RS, d, rk, en ? 16'((r - rs) >> dd) : d, abort_at, idx, ab); if (ab) return;
            end
            for (int c = 0; c < nc; c++) begin
                if (mid_rs >= 0 && r == 1 && c == 0) row_start = 16'(mid_rs);
                d = seq ? 16'(r * nc + c) : 16'($urandom);
                put(PX, d, rk && in_win(c, cs, ncl, dd, en), d, abort_at, idx, ab); if (ab) return;
            end
            if (has_re) begin
                d = 16'($urandom); put(RE, d, rk, d, abort_at, idx, ab); if (ab) return;
            end
            if (rk) kr++;
            if (rk && (has_re || kc > 0)) rows_x++;
        end
        d = 16'($urandom); put(FE, d, 1, d, abort_at, idx, ab); if (ab) return;
        idle(4);
        chk("out_rows", 32'(out_rows), 32'(rows_x));
        chk("out_cols", 32'(out_cols), 32'(kr > 0 ? kc : 0));
    endtask

    initial begin
        #1 resetb = 1'b0;
        #1;
        chk("init_dvo", 32'(dvo), 0);
        chk("init_out_rows", 32'(out_rows), 0);
        chk("init_out_cols", 32'(out_cols), 0);
        idle(2);
        resetb = 1'b1;
        idle(2);
        // bypass, basic crop, missing markers, mid-frame config change, far-out window
        send_frame(4, 4, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1, 1);
        send_frame(4, 4, 1, 1, 2, 1, 2, 0, 0, 0, -1, -1, 1);
        send_frame(3, 4, 1, 0, 0, 2, 0, 0, 1, 1, -1, -1, 1);
        send_frame(4, 4, 1, 0, 0, 0, 0, 0, 0, 0, 2, -1, 1);
        send_frame(4, 4, 1, 2, 0, 0, 0, 0, 0, 0, -1, -1, 1);
        send_frame(4, 4, 1, 65535, 65535, 0, 0, 0, 0, 0, -1, -1, 1);
        send_frame(4, 4, 1, 0, 0, 65535, 65535, 0, 0, 0, -1, -1, 1);
        // reset lands during row 2, then a clean cropped frame
        send_frame(4, 4, 1, 0, 0, 0, 0, 0, 0, 0, -1, 19, 1);
        send_frame(4, 4, 1, 1, 2, 1, 2, 0, 0, 0, -1, -1, 1);
        send_frame(4, 4, 1, 0, 0, 0, 0, 1, 0, 0, -1, -1, 1);
        send_frame(5, 6, 1, 1, 4, 1, 0, 1, 0, 0, -1, -1, 0);
        for (int i = 0; i < 30; i++)
            send_frame($urandom_range(1, 6), $urandom_range(1, 6), 1'($urandom), $urandom_range(0, 6),
                       $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), 1'($urandom),
                       1'($urandom), 1'($urandom), -1, -1, 0);
        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/image_crop.md
Name: image_crop

Overview:
- Windowing stage placed directly downstream of the imager receive stage. Consumes its typed pixel stream (dv/dtype/data) and forwards only pixels inside a programmable row/column window.
- Frame, row and header markers are forwarded so the stream stays well formed; row markers are renumbered relative to the window.
- Outputs feed the rest of the image pipeline (colour assignment, packing) unchanged in format.

Parameters:
- DATA_WIDTH, 16, width of datai/datao
- DIM_WIDTH, 16, width of window config and row/col counters

Ports:
- clk  input  1  pipeline clock
- resetb  input  1  asynchronous active-low reset
- enable  input  1  crop enable; sampled only at FRAME_START
- row_start  input  DIM_WIDTH  first kept row
- num_rows  input  DIM_WIDTH  kept row count; 0 = to end of frame
- col_start  input  DIM_WIDTH  first kept column
- num_cols  input  DIM_WIDTH  kept column count; 0 = to end of row
- dvi  input  1  data valid in
- dtypei  input  `DTYPE_WIDTH  data type in
- datai  input  DATA_WIDTH  data in
- dvo  output  1  data valid out
- dtypeo  output  `DTYPE_WIDTH  data type out
- datao  output  DATA_WIDTH  data out
- out_rows  output  DIM_WIDTH  rows emitted in last completed frame
- out_cols  output  DIM_WIDTH  pixels emitted in last emitted row of last frame

Behaviour:
- Reset: dvo=0, dtypeo=0, datao=0, out_rows=0, out_cols=0, all counters 0, latched config 0 (state BYPASS).
- Latency: exactly 1 clk, registered outputs. No backpressure. Cycles with dvi=0 produce dvo=0, dtypeo=0, datao=0.
- States:
  - BYPASS: every valid word forwarded unmodified.
  - CROP: windowing active.
- State update happens only on a valid FRAME_START:
  - latch enable and the four config inputs;
  - go to CROP if enable=1, else BYPASS.
  - Mid-frame changes to config or enable have no effect until the next FRAME_START.
- Counters (both states):
  - FRAME_START: row_cnt=0, col_cnt=0, emitted-row count=0.
  - ROW_START: col_cnt=0.
  - PIXEL: col_cnt+1.
  - ROW_END: row_cnt+1, col_cnt=0.
  - Row 0 may arrive without ROW_START (FRAME_START trumps it); clearing at FRAME_START covers this.
- Window tests use DIM_WIDTH+1 bit arithmetic so start+count never wraps:
  - row_in = row_cnt>=row_start_l && (num_rows_l==0 || row_cnt<row_start_l+num_rows_l)
  - col_in defined likewise with col_cnt.
- CROP forwarding:
  - FRAME_START, FRAME_END, HEADER_START, HEADER, HEADER_END and unknown dtypes: forwarded unchanged.
  - ROW_START: forwarded only if row_in; datao = row_cnt-row_start_l, zero-extended.
  - PIXEL: forwarded only if row_in && col_in.
  - ROW_END: forwarded only if row_in.
  - Dropped words give dvo=0, dtypeo=0, datao=0.
- Stats (both states):
  - emitted-row count +1 on each forwarded ROW_END, or on FRAME_END when the final row had pixels forwarded but no ROW_END (ROW_END trumped by FRAME_END).
  - Per-row emitted-pixel count is reset at ROW_START.
  - On FRAME_END, out_rows/out_cols load these counts, visible the cycle after FRAME_END appears on dtypeo.
- Window fully outside frame: only frame and header markers emitted; out_rows=0.
- Counters saturate at all-ones rather than wrap.
- Reset asserted mid-frame: immediate return to reset values. The next frame start resumes normally.

Optional Feature:
- Macro: IMAGE_CROP_DECIMATE_EN.
- Defined: adds input port decimate (1 bit), latched at FRAME_START with the other config.
  - When latched 1 in CROP, only rows and columns whose offset from row_start_l/col_start_l is even are kept.
  - Renumbered ROW_START datao = (row_cnt-row_start_l)>>1.
  - num_rows/num_cols still bound the pre-decimation window.
- Undefined: no decimate port; behaviour as if decimate=0.

Test Plan:
- Bypass: enable=0, 4x4 frame, pixels 0..15 -> output identical to input delayed 1 clk; out_rows=4, out_cols=4.
- Basic crop: enable=1, row_start=1, num_rows=2, col_start=1, num_cols=2, 4x4 frame pixel=r*4+c.
  - Expect pixels 5,6,9,10.
  - ROW_START datao 0 then 1.
  - FRAME_START/FRAME_END and header block forwarded intact.
  - out_rows=2, out_cols=2.
- Missing markers: row 0 without ROW_START, last row without ROW_END, crop row_start=0, num_rows=0, col_start=2, num_cols=0 on a 3x4 frame.
  - Expect pixels at cols 2,3 of all rows.
  - out_rows=3, out_cols=2.
- Config change mid-frame: change row_start 0->2 during row 1 -> current frame uses 0; next frame uses 2.
- Boundary: row_start=16'hFFFF, num_rows=16'hFFFF -> no wrap; no rows kept on 4-row frame; out_rows=0.
- Reset mid-frame: assert resetb=0 during row 2 -> outputs 0 immediately; next full frame cropped correctly. With IMAGE_CROP_DECIMATE_EN, decimate=1 on 4x4 full window -> pixels 0,2,8,10.
